// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word/double accesses over an aligned 64-bit memory port,
// sub-doubleword stores by read-modify-write. Optional macro: LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_misaligned,
    output logic [63:0] o_rdata,
    output logic [63:0] o_mem_addr,
    output logic        o_mem_wr,
    output logic [63:0] o_mem_wdata,
    input  logic [63:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [2:0]  r_off;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;
    logic [1:0]  r_cnt;

    logic        w_accept;
    logic        w_misal;
    logic [2:0]  w_off;
    logic [63:0] w_rd_shift;
    logic [63:0] w_load;
    logic [7:0]  w_lanes;
    logic [7:0]  w_byte_en;
    logic [63:0] w_wr_shift;
    logic [63:0] w_merged;

    assign w_accept = (r_state == S_IDLE) && i_req;

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_mis;

    always_comb begin
        w_off = i_addr[2:0];
        case (i_size)
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = i_addr[0];
            2'b10:   w_misal = |i_addr[1:0];
            default: w_misal = |i_addr[2:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mis <= 1'b0;
        end else if (w_accept) begin
            r_mis <= w_misal;
        end
    end

    assign o_misaligned = (r_state == S_DONE) && r_mis;
`else
    // Without the check, the lane offset is rounded down to the access size.
    always_comb begin
        w_misal = 1'b0;
        case (i_size)
            2'b00:   w_off = i_addr[2:0];
            2'b01:   w_off = {i_addr[2:1], 1'b0};
            2'b10:   w_off = {i_addr[2], 2'b00};
            default: w_off = 3'b000;
        endcase
    end

    assign o_misaligned = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        o_busy   = 1'b1;
        o_done   = 1'b0;
        o_mem_wr = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_req) begin
                    if (w_misal) begin
                        w_next = S_DONE;
                    end else if (i_we && (i_size == 2'b11)) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD: begin
                if (r_cnt == 2'd0) begin
                    w_next = r_we ? S_WR : S_DONE;
                end
            end
            S_WR: begin
                o_mem_wr = 1'b1;
                w_next   = S_DONE;
            end
            default: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    // Load path: lane-align the returned doubleword, then extend.
    always_comb begin
        w_rd_shift = i_mem_rdata >> {r_off, 3'b000};
        case (r_size)
            2'b00:   w_load = r_uns ? {56'd0, w_rd_shift[7:0]}  : {{56{w_rd_shift[7]}},  w_rd_shift[7:0]};
            2'b01:   w_load = r_uns ? {48'd0, w_rd_shift[15:0]} : {{48{w_rd_shift[15]}}, w_rd_shift[15:0]};
            2'b10:   w_load = r_uns ? {32'd0, w_rd_shift[31:0]} : {{32{w_rd_shift[31]}}, w_rd_shift[31:0]};
            default: w_load = w_rd_shift;
        endcase
    end

    // Store path: byte enables select new bytes over the read doubleword.
    always_comb begin
        case (r_size)
            2'b00:   w_lanes = 8'h01;
            2'b01:   w_lanes = 8'h03;
            2'b10:   w_lanes = 8'h0F;
            default: w_lanes = 8'hFF;
        endcase
        w_byte_en  = w_lanes << r_off;
        w_wr_shift = r_wdata << {r_off, 3'b000};
        w_merged   = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            w_merged[8*b +: 8] = w_byte_en[b] ? w_wr_shift[8*b +: 8] : i_mem_rdata[8*b +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we        <= 1'b0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_off       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= i_we;
                r_size     <= i_size;
                r_uns      <= i_uns;
                r_off      <= w_off;
                r_wdata    <= i_wdata;
                r_mem_addr <= {i_addr[63:3], 3'b000};
                r_cnt      <= 2'(RD_LAT);
                if (i_we && (i_size == 2'b11)) begin
                    r_mem_wdata <= i_wdata;
                end
            end
            if (r_state == S_RD) begin
                if (r_cnt != 2'd0) begin
                    r_cnt <= r_cnt - 2'd1;
                end else if (r_we) begin
                    r_mem_wdata <= w_merged;
                end else begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign o_rdata     = r_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table vectors, hand-written multi-cycle sequences and
// randomized accesses checked against a byte-level memory model.
module tb_load_store_unit;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset, req, we, uns;
    logic [1:0]  size;
    logic [63:0] addr, wdata;
    logic        busy, done, misaligned, mem_wr;
    logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.RD_LAT(LAT)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_size(size), .i_uns(uns),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_misaligned(misaligned),
        .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_wr(mem_wr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Memory seen by the DUT: RD_LAT-stage read pipe, write on mem_wr.
    logic [63:0] dut_mem [32];
    logic [63:0] rd_pipe [LAT];
    logic        mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 32; i++) dut_mem[i] <= '0;
        end else if (mem_wr) begin
            dut_mem[mem_addr[7:3]] <= mem_wdata;
        end
        rd_pipe[0] <= dut_mem[mem_addr[7:3]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Reference model state.
    logic [63:0] ref_mem [32];
    logic [63:0] exp_rdata;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input bit w, input bit [1:0] sz, input bit u, input logic [63:0] a,
                         input logic [63:0] wd, output bit e_mis, output int e_done, output int e_wr);
        int unsigned n, off, idx;
        bit          check;
        logic [63:0] v, m;
        n   = 1 << sz;
        off = a[2:0];
        idx = a[7:3];
`ifdef LSU_MISALIGN_CHECK_EN
        check = 1'b1;
`else
        check = 1'b0;
`endif
        e_mis = 1'b0;
        e_wr  = -1;
        if (check && (a % n) != 0) begin
            e_mis  = 1'b1;
            e_done = 0;
            return;
        end
        off = off - (off % n);
        if (!w) begin
            v = ref_mem[idx] >> (8 * off);
            if (n < 8) begin
                m = (64'd1 << (8 * n)) - 64'd1;
                v = v & m;
                if (!u && v[8*n-1]) v = v | ~m;
            end
            exp_rdata = v;
            e_done    = LAT + 1;
        end else if (n == 8) begin
            ref_mem[idx] = wd;
            e_wr   = 0;
            e_done = 1;
        end else begin
            for (int unsigned b = 0; b < n; b++) ref_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
            e_wr   = LAT + 1;
            e_done = LAT + 2;
        end
    endtask

    // One access: request for one cycle, garbage on inputs afterwards, observe until done.
    task automatic access(input string tag, input bit w, input bit [1:0] sz, input bit u,
                          input logic [63:0] a, input logic [63:0] wd,
                          output int done_c, output bit mis);
        int  wr_c, nwr, e_done, e_wr;
        bit  addr_ok, busy_ok, idle_ok, e_mis;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        done_c = -1; wr_c = -1; nwr = 0; mis = 1'b0; addr_ok = 1'b1; busy_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_addr !== {a[63:3], 3'b000}) addr_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (mem_wr === 1'b1) begin nwr++; wr_c = k; end
            if (done === 1'b1) begin done_c = k; mis = misaligned; break; end
        end
        @(negedge clk);
        idle_ok = (busy === 1'b0) && (done === 1'b0) && (mem_wr === 1'b0);
        model(w, sz, u, a, wd, e_mis, e_done, e_wr);
        chk({tag, "_done_cycle"}, 64'(done_c), 64'(e_done));
        chk({tag, "_misaligned"}, 64'(mis), 64'(e_mis));
        chk({tag, "_wr_cycle"}, 64'(wr_c), 64'(e_wr));
        chk({tag, "_wr_count"}, 64'(nwr), 64'((e_wr >= 0) ? 1 : 0));
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_mem_word"}, dut_mem[a[7:3]], ref_mem[a[7:3]]);
        chk({tag, "_mem_addr_held"}, 64'(addr_ok), 64'd1);
        chk({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        chk({tag, "_idle_after"}, 64'(idle_ok), 64'd1);
    endtask

    typedef struct {
        bit          w;
        bit [1:0]    sz;
        bit          u;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] e_rdata;
        logic [63:0] e_mem;
        int          e_done;
        bit          e_mis;
    } vec_t;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam logic [63:0] R9_MEM  = 64'h11223344AB667788;
    localparam int          R9_DONE = 0;
    localparam bit          R_MIS   = 1'b1;
    localparam logic [63:0] R10_RD  = 64'hFFFFFFFF8000F0FF;
    localparam int          R10_DONE = 0;
`else
    localparam logic [63:0] R9_MEM  = 64'h11223344AB66BEEF;
    localparam int          R9_DONE = 3;
    localparam bit          R_MIS   = 1'b0;
    localparam logic [63:0] R10_RD  = 64'h000000000000BEEF;
    localparam int          R10_DONE = 2;
`endif

    vec_t tbl [13];

    initial begin
        int  dc, dc2, k, nwr, nbad;
        bit  mis, flag;
        logic [63:0] a, wd;
        reset = 1'b1; req = 1'b0; we = 1'b0; size = '0; uns = 1'b0; addr = '0; wdata = '0;
        mem_clear = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        exp_rdata = '0;

        tbl[0]  = '{1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 64'h0, 64'h1122334455667788, 1, 1'b0};
        tbl[1]  = '{1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h1122334455667788, 64'h1122334455667788, 2, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 64'h13, 64'hFFFFFFFFFFFFFFAB, 64'h1122334455667788, 64'h11223344AB667788, 3, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 1'b0, 64'h00, 64'h000000008000F0FF, 64'h1122334455667788, 64'h000000008000F0FF, 1, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 64'h00, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h000000008000F0FF, 2, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 64'h00, 64'h0, 64'h00000000000000FF, 64'h000000008000F0FF, 2, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 64'h02, 64'h0, 64'hFFFFFFFFFFFF8000, 64'h000000008000F0FF, 2, 1'b0};
        tbl[7]  = '{1'b0, 2'd2, 1'b1, 64'h00, 64'h0, 64'h000000008000F0FF, 64'h000000008000F0FF, 2, 1'b0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 64'h00, 64'h0, 64'hFFFFFFFF8000F0FF, 64'h000000008000F0FF, 2, 1'b0};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 64'h11, 64'h000000000000BEEF, 64'hFFFFFFFF8000F0FF, R9_MEM, R9_DONE, R_MIS};
        tbl[10] = '{1'b0, 2'd1, 1'b1, 64'h11, 64'h0, R10_RD, R9_MEM, R10_DONE, R_MIS};
        tbl[11] = '{1'b1, 2'd2, 1'b0, 64'h1C, 64'h12345678DEADBEEF, R10_RD, 64'hDEADBEEF00000000, 3, 1'b0};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'hDEADBEEF00000000, 64'hDEADBEEF00000000, 2, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_misaligned", 64'(misaligned), 64'd0);
        chk("reset_mem_wr", 64'(mem_wr), 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        chk("reset_mem_wdata", mem_wdata, 64'd0);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            access($sformatf("row%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, dc, mis);
            chk($sformatf("row%0d_tbl_done", i), 64'(dc), 64'(tbl[i].e_done));
            chk($sformatf("row%0d_tbl_mis", i), 64'(mis), 64'(tbl[i].e_mis));
            chk($sformatf("row%0d_tbl_rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("row%0d_tbl_mem", i), dut_mem[tbl[i].a[7:3]], tbl[i].e_mem);
        end

        // Second req during RD is ignored (store to 0x40 must never happen).
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd3; uns = 1'b0; addr = 64'h18;
        @(posedge clk); #1;
        we = 1'b1; addr = 64'h40; wdata = 64'hA5A5A5A5A5A5A5A5;
        dc = -1; nwr = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_wr === 1'b1) nwr++;
            if (done === 1'b1) begin dc = k; break; end
        end
        req = 1'b0;
        flag = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || mem_wr !== 1'b0) flag = 1'b0;
        end
        model(1'b0, 2'd3, 1'b0, 64'h18, 64'h0, mis, k, dc2);
        chk("ignore_done_cycle", 64'(dc), 64'(LAT + 1));
        chk("ignore_no_wr", 64'(nwr), 64'd0);
        chk("ignore_stays_idle", 64'(flag), 64'd1);
        chk("ignore_mem40", dut_mem[8], ref_mem[8]);
        chk("ignore_rdata", rdata, exp_rdata);

        // req held through DONE: accepted in the following IDLE cycle.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd3; uns = 1'b0; addr = 64'h10;
        @(posedge clk);
        dc = -1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin dc = k; break; end
        end
        chk("held_first_done", 64'(dc), 64'(LAT + 1));
        @(negedge clk);
        chk("held_idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("held_reaccept_busy", 64'(busy), 64'd1);
        dc2 = -1;
        for (k = 0; k < 20; k++) begin
            if (done === 1'b1) begin dc2 = k; break; end
            @(negedge clk);
        end
        model(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, mis, k, dc);
        chk("held_second_done", 64'(dc2), 64'(LAT + 1));
        chk("held_rdata", rdata, exp_rdata);

        // Reset during a sub-word store RD.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd0; addr = 64'h21; wdata = 64'h55;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        flag = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (mem_wr !== 1'b0 || done !== 1'b0) flag = 1'b0;
        end
        chk("rst_mid_no_wr_done", 64'(flag), 64'd1);
        chk("rst_mid_mem", dut_mem[4], ref_mem[4]);
        chk("rst_mid_rdata", rdata, 64'd0);

        // Randomized accesses against the model.
        for (int i = 0; i < 300; i++) begin
            a  = 64'($urandom_range(0, 255));
            wd = {$urandom, $urandom};
            access($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom), a, wd, dc, mis);
        end

        nbad = 0;
        for (int i = 0; i < 32; i++) if (dut_mem[i] !== ref_mem[i]) nbad++;
        chk("final_mem_words_bad", 64'(nbad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
